karaoke_io_bridge: RTL and testbench
====================================

// Module: karaoke_io_bridge
// PURPOSE
//  Peripheral-side endpoint of the processor's register-file side port. Turns pitch-detector
//  note events into a mailbox word driven onto the regfile input port (register 5). Reads the
//  score word from the regfile output port (register 3). Converts the score to BCD for the
//  seven-segment display.
//  Sits between the pitch detector / display driver and the processor top level. Single clock domain.
// PARAMETERS
//  HOLD_CYCLES  default 64  minimum cycles a note stays in the mailbox before the next one is accepted
//  SCORE_BITS   default 16  score bits converted to BCD
//  DIGITS       default 5   BCD digits output; must satisfy 10^DIGITS > 2^SCORE_BITS-1
// PORTS
//  clock         in   1          system clock; block logic on posedge
//  ctrl_reset    in   1          reset ctrl_reset, asynchronous, active-high
//  note_valid    in   1          pitch detector offers note_code
//  note_code     in   8          detected note (0 = silence)
//  note_ready    out  1          bridge can accept a note
//  score_word    in   32         score register value from regfile output port
//  mailbox_word  out  32         to regfile input port: {1'b1, seq[6:0], 8'h00, note[7:0], hold_cnt[7:0]}
//  bcd_digits    out  4*DIGITS   score in BCD, digit 0 = LSD in bits [3:0]
//  bcd_valid     out  1          bcd_digits holds at least one completed conversion
//  score_changed out  1          1-cycle pulse when bcd_digits is updated with a different value
// BEHAVIOUR
//  Reset (async, immediate):
//   - mailbox_word=0, seq=0, note_ready=1.
//   - bcd_digits=0, bcd_valid=0, score_changed=0.
//   - FSM=IDLE; pending-conversion flag set, so the first score is converted after reset.
//  Note mailbox:
//   - Accept when note_valid && note_ready at posedge.
//   - Same edge: mailbox_word <= {1,seq+1,8'h00,note_code,8'h00}; seq wraps 127->0; note_ready <= 0.
//   - hold_cnt field counts up once per cycle and saturates at 255. Software uses it as note age.
//   - note_ready returns to 1 once HOLD_CYCLES cycles have elapsed since the accept.
//   - Mailbox keeps its last value indefinitely. Software detects new notes by a seq change.
//   - note_valid while note_ready=0 is ignored. No buffering; the detector must hold the request.
//  Score capture:
//   - score_word is registered every posedge into score_q.
//   - Clamp: if score_q[31]=1 (negative), the value is 0.
//   - Otherwise, if any of score_q[30:SCORE_BITS] is set, the result is all-nines (saturate).
//   - Otherwise the value is score_q[SCORE_BITS-1:0].
//  Converter FSM (shift-add-3 double-dabble, one bit per cycle):
//   - IDLE:
//     - if (clamped value != last_converted) or pending: load the shifter, clear pending -> CONV.
//   - CONV:
//     - SCORE_BITS cycles.
//     - Each cycle: add 3 to every BCD nibble >= 5, then shift left 1.
//     - After the last shift -> DONE.
//   - DONE, one cycle:
//     - bcd_digits <= result; bcd_valid <= 1; last_converted <= source value.
//     - score_changed <= (result != previous bcd_digits).
//     - -> IDLE.
//   - Saturated or clamped values bypass CONV: IDLE -> DONE directly, with the all-nines/zero pattern.
//  Latency: score_word change to bcd_digits update = SCORE_BITS+3 cycles (unsaturated).
//   - Edge N: capture. Edge N+1: IDLE starts. Edges N+2..N+SCORE_BITS+1: CONV. Edge N+SCORE_BITS+2: DONE.
//  Score change during CONV/DONE: the conversion in flight completes with its old value. IDLE then
//   sees the mismatch and reconverts, so only the latest value is ever displayed.
//  Simultaneous note accept and score update: independent paths, no interaction.
//  Reset mid-conversion: aborts immediately; outputs take reset values.
// STRUCTURE
//  Package karaoke_io_pkg:
//   - mailbox field offsets (VALID_BIT=31, SEQ_LSB=24, NOTE_LSB=8, AGE_LSB=0).
//   - NOTE_SILENCE=8'h00.
//   - converter state encoding {IDLE, CONV, DONE}.
//  Sub-module bin2bcd_seq:
//   - start/busy/done interface; holds the double-dabble datapath and the CONV counter.
//  The bridge keeps the mailbox logic, clamp/saturate, and change detection.
// TESTING
//  1. Reset release with score_word=0:
//     - bcd_valid=1 and bcd_digits=0 after 3 cycles (clamped path).
//     - score_changed stays 0.
//     - mailbox_word=0, note_ready=1.
//  2. score_word=12345:
//     - after SCORE_BITS+3 cycles, bcd_digits=20'h12345, bcd_valid=1.
//     - score_changed pulses exactly once.
//  3. score_word=32'hFFFF_FFF6 (-10) -> bcd_digits=0.
//     score_word=32'h0001_0000 -> bcd_digits=20'h99999.
//  4. Note C4 (8'h3C) offered with note_valid held high:
//     - mailbox_word[31:24]=8'h81, [15:8]=8'h3C on the accept edge.
//     - note_ready low for exactly 64 cycles.
//     - a second note is accepted with seq=2 only after that.
//  5. 128 back-to-back accepted notes:
//     - seq field wraps 127->0; bit 31 stays 1.
//     - hold_cnt saturates at 255 when the next note is withheld for 300 cycles.
//  6. Score changed 100->200 mid-CONV, plus ctrl_reset pulsed mid-CONV in a separate run:
//     - final bcd_digits=200 after reconversion.
//     - reset run: outputs zero within the same cycle as the reset assertion.

Source files
------------

// File: rtl/karaoke_io_pkg.sv
// Shared definitions for the karaoke I/O bridge: mailbox field layout,
// the silence note code and the score converter state encoding.
package karaoke_io_pkg;

    localparam int unsigned VALID_BIT = 31;
    localparam int unsigned SEQ_LSB   = 24;
    localparam int unsigned NOTE_LSB  = 8;
    localparam int unsigned AGE_LSB   = 0;

    localparam int unsigned SEQ_BITS  = 7;
    localparam int unsigned NOTE_BITS = 8;
    localparam int unsigned AGE_BITS  = 8;

    localparam logic [7:0] NOTE_SILENCE = 8'h00;
    localparam logic [7:0] AGE_MAX      = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } conv_state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 double dabble), one bit per cycle.
// A start pulse loads the operand; done is high during the final shift cycle.
module bin2bcd_seq #(
    parameter int unsigned BIN_BITS = 16,
    parameter int unsigned DIGITS   = 5
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  start,
    input  logic [BIN_BITS-1:0]   bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(BIN_BITS + 1);

    logic [BcdW+BIN_BITS-1:0] shift_q;
    logic [BcdW+BIN_BITS-1:0] adj;
    logic [CntW-1:0]          cnt_q;

    // Correct every BCD nibble before the shift so it carries properly into the next digit.
    always_comb begin
        adj = shift_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (shift_q[BIN_BITS + 4*d +: 4] >= 4'd5) begin
                adj[BIN_BITS + 4*d +: 4] = shift_q[BIN_BITS + 4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (start && !busy) begin
            shift_q <= {{BcdW{1'b0}}, bin};
            cnt_q   <= CntW'(BIN_BITS);
        end else if (busy) begin
            shift_q <= adj << 1;
            cnt_q   <= cnt_q - CntW'(1);
        end
    end

    assign busy = (cnt_q != '0);
    assign done = (cnt_q == CntW'(1));
    assign bcd  = shift_q[BIN_BITS +: BcdW];

endmodule

// File: rtl/karaoke_io_bridge.sv
// Register-file side-port endpoint: posts pitch-detector notes into a mailbox word and
// converts the clamped score register into BCD digits for the seven-segment display.
module karaoke_io_bridge
    import karaoke_io_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 64,
    parameter int unsigned SCORE_BITS  = 16,
    parameter int unsigned DIGITS      = 5
) (
    input  logic                clock,
    input  logic                ctrl_reset,
    input  logic                note_valid,
    input  logic [7:0]          note_code,
    output logic                note_ready,
    input  logic [31:0]         score_word,
    output logic [31:0]         mailbox_word,
    output logic [4*DIGITS-1:0] bcd_digits,
    output logic                bcd_valid,
    output logic                score_changed
);

    localparam int unsigned BcdW  = 4 * DIGITS;
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
    localparam logic [BcdW-1:0] AllNines = {DIGITS{4'h9}};

    // ---------------------------------------------------------------- note mailbox
    logic                 mb_valid_q;
    logic [SEQ_BITS-1:0]  seq_q;
    logic [NOTE_BITS-1:0] note_q;
    logic [AGE_BITS-1:0]  age_q;
    logic [HoldW-1:0]     hold_q;
    logic                 accept;

    assign accept = note_valid && note_ready;

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            mb_valid_q <= 1'b0;
            seq_q      <= '0;
            note_q     <= NOTE_SILENCE;
            age_q      <= '0;
            hold_q     <= '0;
            note_ready <= 1'b1;
        end else if (accept) begin
            mb_valid_q <= 1'b1;
            seq_q      <= seq_q + SEQ_BITS'(1);
            note_q     <= note_code;
            age_q      <= '0;
            hold_q     <= HoldW'(HOLD_CYCLES);
            note_ready <= 1'b0;
        end else begin
            if (mb_valid_q && (age_q != AGE_MAX)) begin
                age_q <= age_q + AGE_BITS'(1);
            end
            if (!note_ready) begin
                hold_q <= hold_q - HoldW'(1);
                if (hold_q == HoldW'(1)) begin
                    note_ready <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        mailbox_word                         = '0;
        mailbox_word[VALID_BIT]              = mb_valid_q;
        mailbox_word[SEQ_LSB +: SEQ_BITS]    = seq_q;
        mailbox_word[NOTE_LSB +: NOTE_BITS]  = note_q;
        mailbox_word[AGE_LSB +: AGE_BITS]    = age_q;
    end

    // ---------------------------------------------------------------- score clamp
    logic [31:0]           score_q;
    logic [30:0]           high_bits;
    logic                  src_sat;
    logic [SCORE_BITS-1:0] src_val;
    logic [SCORE_BITS:0]   src;
    logic                  bypass;

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            score_q <= '0;
        end else begin
            score_q <= score_word;
        end
    end

    // Source is {saturated, value}; negative scores collapse to zero.
    always_comb begin
        high_bits = score_q[30:0] >> SCORE_BITS;
        src_sat   = 1'b0;
        src_val   = '0;
        if (!score_q[31]) begin
            if (|high_bits) begin
                src_sat = 1'b1;
            end else begin
                src_val = score_q[SCORE_BITS-1:0];
            end
        end
        src    = {src_sat, src_val};
        bypass = src_sat || (src_val == '0);
    end

    // ---------------------------------------------------------------- converter control
    conv_state_e         state_q;
    logic                pending_q;
    logic [SCORE_BITS:0] last_q;
    logic [SCORE_BITS:0] cur_q;
    logic                byp_q;
    logic                need;
    logic                conv_start;
    logic                conv_busy;
    logic                conv_done;
    logic [BcdW-1:0]     conv_bcd;
    logic [BcdW-1:0]     result;

    assign need       = pending_q || (src != last_q);
    assign conv_start = (state_q == StIdle) && need && !bypass && !conv_busy;
    assign result     = byp_q ? (cur_q[SCORE_BITS] ? AllNines : '0) : conv_bcd;

    bin2bcd_seq #(
        .BIN_BITS (SCORE_BITS),
        .DIGITS   (DIGITS)
    ) u_bin2bcd (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .start      (conv_start),
        .bin        (src_val),
        .busy       (conv_busy),
        .done       (conv_done),
        .bcd        (conv_bcd)
    );

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_q       <= StIdle;
            pending_q     <= 1'b1;
            last_q        <= '0;
            cur_q         <= '0;
            byp_q         <= 1'b0;
            bcd_digits    <= '0;
            bcd_valid     <= 1'b0;
            score_changed <= 1'b0;
        end else begin
            score_changed <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (need) begin
                        pending_q <= 1'b0;
                        cur_q     <= src;
                        byp_q     <= bypass;
                        state_q   <= bypass ? StDone : StConv;
                    end
                end
                StConv: begin
                    if (conv_done) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    bcd_digits    <= result;
                    bcd_valid     <= 1'b1;
                    last_q        <= cur_q;
                    score_changed <= (result != bcd_digits);
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_karaoke_io_bridge.sv
// Scoreboard bench for karaoke_io_bridge: stimulus pushes expected mailbox words and BCD
// results; a monitor pops and compares on every note accept and every score_changed pulse.
module tb_karaoke_io_bridge;

    localparam int SB   = 16;
    localparam int DG   = 5;
    localparam int HOLD = 64;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        note_valid = 1'b0;
    logic [7:0]  note_code = 8'h00;
    logic        note_ready;
    logic [31:0] score_word = 32'd0;
    logic [31:0] mailbox_word;
    logic [19:0] bcd_digits;
    logic        bcd_valid;
    logic        score_changed;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_count = 0, acc_cycle = 0;
    int pulse_count = 0, pulse_cycle = 0;
    int set_cyc = 0;
    logic [6:0] exp_seq = 7'd0;

    logic [31:0] mb_q[$];
    logic [19:0] bcd_q[$];

    karaoke_io_bridge #(
        .HOLD_CYCLES (HOLD),
        .SCORE_BITS  (SB),
        .DIGITS      (DG)
    ) dut (
        .clock         (clock),
        .ctrl_reset    (ctrl_reset),
        .note_valid    (note_valid),
        .note_code     (note_code),
        .note_ready    (note_ready),
        .score_word    (score_word),
        .mailbox_word  (mailbox_word),
        .bcd_digits    (bcd_digits),
        .bcd_valid     (bcd_valid),
        .score_changed (score_changed)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Monitor: compares whatever the DUT presents against the head of the scoreboard queues.
    initial begin : monitor
        logic acc;
        logic [31:0] exp_mb;
        logic [19:0] exp_bcd;
        forever begin
            @(posedge clock);
            cyc++;
            acc = note_valid && note_ready && !ctrl_reset;
            #1;
            if (acc) begin
                acc_count++;
                acc_cycle = cyc;
                if (mb_q.size() == 0) begin
                    flag_fail("unexpected_accept");
                end else begin
                    exp_mb = mb_q.pop_front();
                    check("mailbox_word", mailbox_word, exp_mb);
                end
            end
            if (score_changed) begin
                pulse_count++;
                pulse_cycle = cyc;
                if (bcd_q.size() == 0) begin
                    flag_fail("unexpected_score_changed");
                end else begin
                    exp_bcd = bcd_q.pop_front();
                    check("bcd_digits", 32'(bcd_digits), 32'(exp_bcd));
                    check("bcd_valid", 32'(bcd_valid), 32'd1);
                end
            end
        end
    end

    function automatic logic [31:0] mb_word(input logic [6:0] seq, input logic [7:0] code);
        return {1'b1, seq, 8'h00, code, 8'h00};
    endfunction

    task automatic set_score(input logic [31:0] v, input logic [19:0] exp);
        @(negedge clock);
        score_word = v;
        bcd_q.push_back(exp);
        set_cyc = cyc;
    endtask

    task automatic wait_pulses(input int target, input int bound, input string name);
        for (int i = 0; i < bound && pulse_count < target; i++) @(negedge clock);
        if (pulse_count < target) flag_fail(name);
    endtask

    task automatic wait_accept(input int target, input int bound, input string name);
        for (int i = 0; i < bound && acc_count < target; i++) @(negedge clock);
        if (acc_count < target) flag_fail(name);
    endtask

    task automatic offer_note(input logic [7:0] code);
        exp_seq    = exp_seq + 7'd1;
        note_valid = 1'b1;
        note_code  = code;
        mb_q.push_back(mb_word(exp_seq, code));
    endtask

    initial begin : stimulus
        int p0, a0, t1, low;
        logic [31:0] last_mb;

        ctrl_reset = 1'b0;
        #1 ctrl_reset = 1'b1;
        #1;
        check("rst_mailbox", mailbox_word, 32'd0);
        check("rst_note_ready", 32'(note_ready), 32'd1);
        check("rst_bcd_digits", 32'(bcd_digits), 32'd0);
        check("rst_bcd_valid", 32'(bcd_valid), 32'd0);
        @(negedge clock);
        @(negedge clock);
        ctrl_reset = 1'b0;

        // 1: first conversion after reset takes the zero path
        repeat (3) @(posedge clock);
        #1;
        check("t1_bcd_valid", 32'(bcd_valid), 32'd1);
        check("t1_bcd_digits", 32'(bcd_digits), 32'd0);
        check("t1_no_pulse", 32'(pulse_count), 32'd0);
        check("t1_mailbox", mailbox_word, 32'd0);
        check("t1_note_ready", 32'(note_ready), 32'd1);

        // 2: plain conversion with full latency
        p0 = pulse_count;
        set_score(32'd12345, 20'h12345);
        wait_pulses(p0 + 1, 60, "t2_pulse_timeout");
        check("t2_latency", 32'(pulse_cycle - set_cyc), 32'(SB + 3));
        repeat (30) @(negedge clock);
        check("t2_single_pulse", 32'(pulse_count - p0), 32'd1);
        check("t2_bcd_hold", 32'(bcd_digits), 32'h12345);

        // 3: negative clamps to zero, out-of-range saturates to all nines
        p0 = pulse_count;
        set_score(32'hFFFF_FFF6, 20'h00000);
        wait_pulses(p0 + 1, 20, "t3_neg_timeout");
        check("t3_neg_latency", 32'(pulse_cycle - set_cyc), 32'd3);
        set_score(32'h0001_0000, 20'h99999);
        wait_pulses(p0 + 2, 20, "t3_sat_timeout");
        check("t3_sat_latency", 32'(pulse_cycle - set_cyc), 32'd3);

        // 4: note hold-off
        @(negedge clock);
        a0 = acc_count;
        offer_note(8'h3C);
        wait_accept(a0 + 1, 10, "t4_first_accept");
        t1 = acc_cycle;
        offer_note(8'h40);
        low = 0;
        for (int i = 0; i < HOLD; i++) begin
            if (!note_ready) low++;
            @(negedge clock);
        end
        check("t4_ready_low_cycles", 32'(low), 32'(HOLD));
        check("t4_ready_back", 32'(note_ready), 32'd1);
        wait_accept(a0 + 2, 10, "t4_second_accept");
        check("t4_accept_gap", 32'(acc_cycle - t1), 32'(HOLD + 1));

        // 5: 128 more notes wrap seq; then age saturates
        for (int k = 0; k < 128; k++) begin
            a0 = acc_count;
            offer_note(8'(k) ^ 8'h5A);
            wait_accept(a0 + 1, 100, "t5_accept");
        end
        note_valid = 1'b0;
        last_mb = mb_word(exp_seq, 8'(127) ^ 8'h5A);
        check("t5_seq_wrapped", 32'(mailbox_word[30:24]), 32'd2);
        repeat (100) @(negedge clock);
        check("t5_age_100", 32'(mailbox_word[7:0]), 32'd100);
        repeat (200) @(negedge clock);
        check("t5_age_sat", 32'(mailbox_word[7:0]), 32'd255);
        check("t5_mailbox_kept", {mailbox_word[31:8], 8'h00}, last_mb);

        // 6a: score change mid-conversion; old value finishes, then the new one is shown
        p0 = pulse_count;
        set_score(32'd100, 20'h00100);
        repeat (5) @(negedge clock);
        set_score(32'd200, 20'h00200);
        wait_pulses(p0 + 2, 80, "t6_reconv_timeout");
        check("t6_final_bcd", 32'(bcd_digits), 32'h00200);

        // 6b: reset mid-conversion
        @(negedge clock);
        score_word = 32'd300;
        repeat (5) @(negedge clock);
        #2 ctrl_reset = 1'b1;
        #1;
        check("t6_rst_bcd", 32'(bcd_digits), 32'd0);
        check("t6_rst_valid", 32'(bcd_valid), 32'd0);
        check("t6_rst_changed", 32'(score_changed), 32'd0);
        check("t6_rst_mailbox", mailbox_word, 32'd0);
        check("t6_rst_ready", 32'(note_ready), 32'd1);
        exp_seq = 7'd0;
        @(negedge clock);
        ctrl_reset = 1'b0;
        p0 = pulse_count;
        bcd_q.push_back(20'h00300);
        wait_pulses(p0 + 1, 60, "t6_post_reset_timeout");
        check("t6_post_reset_bcd", 32'(bcd_digits), 32'h00300);

        repeat (5) @(negedge clock);
        check("scoreboard_drained", 32'(mb_q.size() + bcd_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
